bcd_to_bin_serial: RTL

- Sequential decimal-to-binary converter: the inverse of the binary-to-two-digit 7-segment decoding path.
- Accepts a packed BCD number from switch entry, for example two decimal digits on SW.
- Produces the equivalent unsigned binary value using reverse double-dabble, one bit per clock.
- Sits between user decimal entry and binary datapath logic (counters, comparators, LEDR display); uses a START/BUSY/DONE handshake.

---
 rtl/bcd_to_bin_serial_if.sv | 15 +
 rtl/bcd_to_bin_serial.sv | 101 ++++++++++
 2 files changed

// File: rtl/bcd_to_bin_serial_if.sv
// Handshake and data bundle for the serial BCD-to-binary converter.
interface bcd_to_bin_serial_if #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
);
  logic                  START;
  logic [4*DIGITS-1:0]   BCD_IN;
  logic [BIN_W-1:0]      BIN_OUT;
  logic                  BUSY;
  logic                  DONE;
  logic                  ERR;

  modport master (output START, BCD_IN, input BIN_OUT, BUSY, DONE, ERR);
  modport slave  (input START, BCD_IN, output BIN_OUT, BUSY, DONE, ERR);
endinterface

// File: rtl/bcd_to_bin_serial.sv
// Reverse double-dabble: packed BCD in, unsigned binary out, one result bit per clock.
module bcd_to_bin_serial #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  bcd_to_bin_serial_if.slave bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CW    = $clog2(BIN_W + 1);
  localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [BCD_W-1:0] s_q, s_d;
  logic [BIN_W-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic [BCD_W-1:0]  s_sh, s_adj;
  logic [BIN_W-1:0]  b_nx;
  logic [DIGITS-1:0] dig_bad;

  // One iteration: shift {S,B} right, then undo the doubling in each digit (>=8 -> -3).
  assign s_sh = {1'b0, s_q[BCD_W-1:1]};
  assign b_nx = {s_q[0], b_q[BIN_W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    logic [3:0] d;
    assign d                = s_sh[4*g +: 4];
    assign s_adj[4*g +: 4]  = (d >= 4'd8) ? d - 4'd3 : d;
    assign dig_bad[g]       = bus.BCD_IN[4*g +: 4] > 4'd9;
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.START) begin
          if (|dig_bad) begin
            bin_d  = '0;
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            s_d     = bus.BCD_IN;
            b_d     = '0;
            cnt_d   = '0;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        s_d   = s_adj;
        b_d   = b_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          bin_d   = b_nx;
          err_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      s_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign bus.BIN_OUT = bin_q;
  assign bus.BUSY    = (state_q == SHIFT);
  assign bus.DONE    = done_q;
  assign bus.ERR     = err_q;
endmodule
